ts_sync_flex: RTL and testbench
===============================

# ts_sync_flex

Parametrised TS packet synchroniser for the DDR3 read/write path. Accepts a byte stream with valid gaps and hunts for a configurable sync word at a configurable packet length (188/204). Locks after N consecutive confirmations and tolerates M consecutive missed sync bytes (flywheel) before dropping lock. Emits only locked, packet-aligned bytes with start, last and error markers to the downstream packet buffer.

## Interface
- PKT_LEN, 188: packet length in bytes; legal range 8..255.
- SYNC_WORD, 8'h47: sync byte value.
- LOCK_CNT, 3: consecutive confirmed sync positions after the first candidate needed to lock; range 1..7.
- UNLOCK_CNT, 3: consecutive missed sync positions that drop lock; range 1..7.
- clk  in  1  clock, 125 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- ts_in  in  8  input byte.
- ts_in_valid  in  1  input byte qualifier.
- stat_clr  in  1  synchronous clear of statistics counters.
- ts_out  out  8  aligned output byte; 0 when ts_out_valid=0.
- ts_out_valid  out  1  output byte qualifier.
- ts_out_sync  out  1  marks byte 0 of a packet.
- ts_out_last  out  1  marks byte PKT_LEN-1 of a packet.
- ts_out_err  out  1  with ts_out_sync; the sync byte did not equal SYNC_WORD (flywheel packet).
- sync_lock  out  1  high while in LOCK.
- lock_loss_cnt  out  16  count of LOCK->HUNT transitions.
- sync_err_cnt  out  16  count of missed sync positions while locked.

## Operation
- Input register stage (s1) holds ts_in/ts_in_valid. All decisions use s1. Nothing advances on s1 invalid cycles.
- pos counter: $clog2(PKT_LEN) bits, 0..PKT_LEN-1, wraps to 0. Advances on each valid s1 byte outside HUNT.
- At pos==0, a byte is a "hit" when it equals SYNC_WORD and a "miss" otherwise.
- HUNT:
  - Valid s1 byte == SYNC_WORD -> VERIFY, pos:=1, hit_cnt:=0.
  - Otherwise stay.
- VERIFY:
  - Hit -> hit_cnt+1. When hit_cnt+1 == LOCK_CNT -> LOCK. This byte is emitted as the first locked byte with ts_out_sync=1.
  - Miss -> HUNT. If the missing byte itself equals... it cannot, so the miss byte is discarded and hunting resumes from the next byte.
- LOCK:
  - Hit -> miss_cnt:=0.
  - Miss -> miss_cnt+1. If miss_cnt+1 < UNLOCK_CNT, the byte is emitted with ts_out_sync=1 and ts_out_err=1. If miss_cnt+1 == UNLOCK_CNT -> HUNT; the byte is not emitted and a lock loss is recorded.
- Emission: a valid s1 byte is emitted when in LOCK (except the unlocking byte), or on the VERIFY->LOCK byte.
  - ts_out_sync = (pos==0).
  - ts_out_last = (pos==PKT_LEN-1).
- Leaving LOCK mid-packet does not happen; lock is dropped only at pos 0. The previous packet's last byte has therefore already been emitted.
- State encoding is one-hot: HUNT=3'b001, VERIFY=3'b010, LOCK=3'b100. An illegal state recovers to HUNT on the next clock.

## Timing
- Latency: ts_in sampled at edge k appears on ts_out after edge k+1; two registers, fixed.
- Valid gaps pass through cycle-for-cycle; no buffering and no backpressure.
- Reset (rst_n low, asynchronous):
  - All outputs 0; state HUNT.
  - pos, hit_cnt, miss_cnt and statistics counters 0.
- Release of rst_n takes effect on the next clk edge.
- stat_clr takes effect at the next edge and has priority over a simultaneous increment; the counter reads 0 afterwards.

## Configuration
- Macro: TS_SYNC_FLEX_STAT_EN.
- Defined:
  - lock_loss_cnt increments on each LOCK->HUNT transition.
  - sync_err_cnt increments on each miss in LOCK, including the unlocking miss.
  - Both counters saturate at 16'hFFFF and are cleared by stat_clr.
- Undefined: both counters are tied to 0, stat_clr is ignored, and no counter flops are present.
- The port list is identical in both cases.

## Structure
- Package ts_sync_pkg:
  - State width and one-hot state constants.
  - Default SYNC_WORD 8'h47 and PKT_LEN constants 188/204.
  - Statistics counter width (16).
- Sub-module ts_sync_stat holds the two saturating counters and the clear logic. It is instantiated only under TS_SYNC_FLEX_STAT_EN.

## Test plan
- Clean lock:
  - Stimulus: PKT_LEN=188, LOCK_CNT=3, contiguous valid, 6 packets each starting with 0x47 and payload never 0x47.
  - Response: sync_lock rises on the 4th packet's sync byte; ts_out_sync is asserted on that byte two cycles after input; 3 packets are output; ts_out_last is asserted on every 188th output byte.
- False sync:
  - Stimulus: an isolated 0x47 in payload before the true sync; its +188 byte is 0x00.
  - Response: VERIFY->HUNT; lock is achieved later on true syncs; no output before lock.
- Flywheel:
  - Stimulus: locked stream, UNLOCK_CNT=3, two consecutive packets with sync 0x00, then a good one.
  - Response: both packets are output with ts_out_sync=ts_out_err=1; lock is held; sync_err_cnt=2.
- Loss of lock:
  - Stimulus: three consecutive bad syncs while locked.
  - Response: the third packet is not output; sync_lock falls at that byte; lock_loss_cnt=1; relock needs 4 good syncs.
- Gaps and 204 mode:
  - Stimulus: PKT_LEN=204, ts_in_valid toggling 1/0 randomly.
  - Response: lock is achieved; output valid pattern equals input pattern delayed 2 cycles; sync/last markers land on bytes 0/203.
- Reset and statistics:
  - Stimulus: rst_n asserted mid-packet while locked. Separately, stat_clr asserted concurrently with a miss.
  - Response: all outputs 0 immediately; hunting restarts after release; the counter reads 0 after the stat_clr edge.

Source files
------------

// File: rtl/ts_sync_pkg.sv
// Shared types and constants for the TS packet synchroniser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ts_sync_pkg;

   localparam int STATE_W = 3;

   // One-hot hunt/verify/lock states
   typedef enum logic [STATE_W-1:0] {
      ST_HUNT   = 3'b001,
      ST_VERIFY = 3'b010,
      ST_LOCK   = 3'b100
   } state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'h47;
   localparam int         PKT_LEN_188  = 188;
   localparam int         PKT_LEN_204  = 204;

   // Confirmation / miss counters hold up to 7
   localparam int CNT_W  = 3;
   localparam int STAT_W = 16;

endpackage

// File: rtl/ts_sync_stat.sv
// Saturating lock-loss and sync-error counters with synchronous clear.
// Latency: counts update on the clock edge that sees the increment pulse.
// Backpressure: none; clear wins over a simultaneous increment.
module ts_sync_stat
   import ts_sync_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              loss_inc_i,
   input  logic              err_inc_i,
   output logic [STAT_W-1:0] lock_loss_cnt_o,
   output logic [STAT_W-1:0] sync_err_cnt_o
);

   logic [STAT_W-1:0] loss_q, loss_d;
   logic [STAT_W-1:0] err_q,  err_d;

   // Next count: clear first, then saturating increment
   always_comb begin
      loss_d = loss_q;
      err_d  = err_q;
      if (clr_i) begin
         loss_d = '0;
         err_d  = '0;
      end else begin
         if (loss_inc_i && (loss_q != '1)) loss_d = loss_q + STAT_W'(1);
         if (err_inc_i  && (err_q  != '1)) err_d  = err_q  + STAT_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
         err_q  <= '0;
      end else begin
         loss_q <= loss_d;
         err_q  <= err_d;
      end
   end

   assign lock_loss_cnt_o = loss_q;
   assign sync_err_cnt_o  = err_q;

endmodule

// File: rtl/ts_sync_flex.sv
// TS packet synchroniser: hunts/verifies/locks on the sync byte and emits aligned packets.
// Latency: 2 cycles fixed (input register + output register); TS_SYNC_FLEX_STAT_EN adds statistics counters.
// Backpressure: none; valid gaps pass through cycle-for-cycle.
module ts_sync_flex
   import ts_sync_pkg::*;
#(
   parameter int         PKT_LEN    = PKT_LEN_188,
   parameter logic [7:0] SYNC_WORD  = SYNC_DEFAULT,
   parameter int         LOCK_CNT   = 3,
   parameter int         UNLOCK_CNT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        ts_in,
   input  logic              ts_in_valid,
   input  logic              stat_clr,
   output logic [7:0]        ts_out,
   output logic              ts_out_valid,
   output logic              ts_out_sync,
   output logic              ts_out_last,
   output logic              ts_out_err,
   output logic              sync_lock,
   output logic [STAT_W-1:0] lock_loss_cnt,
   output logic [STAT_W-1:0] sync_err_cnt
);

   localparam int         PW      = $clog2(PKT_LEN);
   localparam logic [3:0] LOCK_N  = 4'(LOCK_CNT);
   localparam logic [3:0] UNLCK_N = 4'(UNLOCK_CNT);

   logic [7:0]     s1_dat_q;
   logic           s1_vld_q;
   state_e         state_q, state_d;
   logic [PW-1:0]  pos_q, pos_d, pos_inc;
   logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
   logic           is_pos0, is_last, is_sync;
   logic           emit, loss_inc, err_inc;

   assign is_pos0 = (pos_q == '0);
   assign is_last = (pos_q == PW'(PKT_LEN - 1));
   assign is_sync = (s1_dat_q == SYNC_WORD);
   assign pos_inc = is_last ? '0 : pos_q + PW'(1);

   // Next-state, position/counter updates and emit decision for the s1 byte
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      hit_d    = hit_q;
      miss_d   = miss_q;
      emit     = 1'b0;
      loss_inc = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (s1_vld_q && is_sync) begin
               state_d = ST_VERIFY;
               pos_d   = PW'(1);
               hit_d   = '0;
            end
         end
         ST_VERIFY: begin
            if (s1_vld_q) begin
               pos_d = pos_inc;
               if (is_pos0) begin
                  if (is_sync) begin
                     hit_d = hit_q + CNT_W'(1);
                     if (({1'b0, hit_q} + 4'd1) == LOCK_N) begin
                        state_d = ST_LOCK;
                        miss_d  = '0;
                        emit    = 1'b1;
                     end
                  end else begin
                     // Candidate failed: discard this byte and hunt from the next one
                     state_d = ST_HUNT;
                     pos_d   = '0;
                  end
               end
            end
         end
         ST_LOCK: begin
            if (s1_vld_q) begin
               pos_d = pos_inc;
               emit  = 1'b1;
               if (is_pos0) begin
                  if (is_sync) begin
                     miss_d = '0;
                  end else begin
                     err_inc = 1'b1;
                     if (({1'b0, miss_q} + 4'd1) == UNLCK_N) begin
                        // Lock only ever drops on byte 0, so no packet is left half-emitted
                        state_d  = ST_HUNT;
                        pos_d    = '0;
                        emit     = 1'b0;
                        loss_inc = 1'b1;
                     end else begin
                        miss_d = miss_q + CNT_W'(1);
                     end
                  end
               end
            end
         end
         default: begin
            state_d = ST_HUNT;
            pos_d   = '0;
            hit_d   = '0;
            miss_d  = '0;
         end
      endcase
   end

   // Input stage, FSM state and aligned output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_dat_q     <= '0;
         s1_vld_q     <= 1'b0;
         state_q      <= ST_HUNT;
         pos_q        <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
         ts_out       <= '0;
         ts_out_valid <= 1'b0;
         ts_out_sync  <= 1'b0;
         ts_out_last  <= 1'b0;
         ts_out_err   <= 1'b0;
      end else begin
         s1_dat_q     <= ts_in;
         s1_vld_q     <= ts_in_valid;
         state_q      <= state_d;
         pos_q        <= pos_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         ts_out       <= emit ? s1_dat_q : 8'h00;
         ts_out_valid <= emit;
         ts_out_sync  <= emit && is_pos0;
         ts_out_last  <= emit && is_last;
         ts_out_err   <= emit && is_pos0 && !is_sync;
      end
   end

   assign sync_lock = (state_q == ST_LOCK);

`ifdef TS_SYNC_FLEX_STAT_EN
   ts_sync_stat u_stat (
      .clk             (clk),
      .rst_n           (rst_n),
      .clr_i           (stat_clr),
      .loss_inc_i      (loss_inc),
      .err_inc_i       (err_inc),
      .lock_loss_cnt_o (lock_loss_cnt),
      .sync_err_cnt_o  (sync_err_cnt)
   );
`else
   logic unused_stat;
   assign unused_stat   = ^{stat_clr, loss_inc, err_inc};
   assign lock_loss_cnt = '0;
   assign sync_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_ts_sync_flex.sv
// Directed bench for ts_sync_flex: per-packet vector table plus a mid-packet reset sequence.
// Latency: checks outputs against the input stream delayed two cycles.
// Backpressure: none; stimulus includes random valid gaps in 204-byte mode.
module tb_ts_sync_flex;

`ifdef TS_SYNC_FLEX_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] ts_in;
   logic       ts_in_valid;
   logic       stat_clr;
   int         tag_in;

   logic [7:0]  a_out, b_out;
   logic        a_vld, b_vld, a_sync, b_sync, a_last, b_last, a_err, b_err, a_lock, b_lock;
   logic [15:0] a_loss, b_loss, a_serr, b_serr;

   ts_sync_flex u_dut (
      .clk(clk), .rst_n(rst_n), .ts_in(ts_in), .ts_in_valid(ts_in_valid), .stat_clr(stat_clr),
      .ts_out(a_out), .ts_out_valid(a_vld), .ts_out_sync(a_sync), .ts_out_last(a_last),
      .ts_out_err(a_err), .sync_lock(a_lock), .lock_loss_cnt(a_loss), .sync_err_cnt(a_serr)
   );

   ts_sync_flex #(.PKT_LEN(204)) u_dut204 (
      .clk(clk), .rst_n(rst_n), .ts_in(ts_in), .ts_in_valid(ts_in_valid), .stat_clr(stat_clr),
      .ts_out(b_out), .ts_out_valid(b_vld), .ts_out_sync(b_sync), .ts_out_last(b_last),
      .ts_out_err(b_err), .sync_lock(b_lock), .lock_loss_cnt(b_loss), .sync_err_cnt(b_serr)
   );

   bit sel;
   int cur_len;
   wire [7:0]  m_out  = sel ? b_out  : a_out;
   wire        m_vld  = sel ? b_vld  : a_vld;
   wire        m_sync = sel ? b_sync : a_sync;
   wire        m_last = sel ? b_last : a_last;
   wire        m_err  = sel ? b_err  : a_err;
   wire        m_lock = sel ? b_lock : a_lock;
   wire [15:0] m_loss = sel ? b_loss : a_loss;
   wire [15:0] m_serr = sel ? b_serr : a_serr;

   initial clk = 1'b0;
   always #4 clk = ~clk;

   int n_chk, n_fail;
   int n_vld, n_sync, n_last, n_err, n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Input history, two cycles deep, to line up with the DUT output
   logic [7:0] d1_dat, d2_dat;
   logic       d1_vld, d2_vld;
   int         d1_tag, d2_tag;
   always @(posedge clk) begin
      d1_dat <= ts_in;  d1_vld <= ts_in_valid; d1_tag <= tag_in;
      d2_dat <= d1_dat; d2_vld <= d1_vld;      d2_tag <= d1_tag;
   end

   // Output monitor: counts markers and flags anything inconsistent with the delayed input
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_vld) begin
            n_vld++;
            if (m_sync) n_sync++;
            if (m_last) n_last++;
            if (m_err)  n_err++;
            if (!d2_vld || m_out !== d2_dat)                   n_bad++;
            if (m_sync !== (d2_tag == 0))                      n_bad++;
            if (m_last !== (d2_tag == cur_len - 1))            n_bad++;
            if (m_err  !== (d2_tag == 0 && d2_dat != 8'h47))   n_bad++;
         end else if (m_out !== 8'h00 || m_sync || m_last || m_err) begin
            n_bad++;
         end
      end
   end

   typedef struct {
      bit         rst;
      bit         sel;
      bit         gaps;
      bit         clr;
      logic [7:0] sync;
      int         sidx;
      logic [7:0] sval;
      bit         out;
      bit         err;
      bit         lock;
      int         serr;
      int         loss;
   } row_t;

   row_t tbl[$];

   function automatic row_t mk(bit rst, bit s, bit g, bit c, logic [7:0] sy, int si, logic [7:0] sv,
                               bit o, bit e, bit l, int se, int lo);
      row_t r;
      r.rst = rst; r.sel = s; r.gaps = g; r.clr = c; r.sync = sy; r.sidx = si; r.sval = sv;
      r.out = o; r.err = e; r.lock = l; r.serr = se; r.loss = lo;
      return r;
   endfunction

   function automatic logic [7:0] pay(int j);
      logic [7:0] v;
      v = 8'(j);
      return (v == 8'h47) ? 8'h48 : v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] b, input int tag, input bit gaps, input bit clr);
      if (gaps && $urandom_range(0, 1) == 1) begin
         ts_in = 8'($urandom); ts_in_valid = 1'b0; tag_in = -1; stat_clr = 1'b0;
         tick();
      end
      ts_in = b; ts_in_valid = 1'b1; tag_in = tag; stat_clr = clr;
      tick();
   endtask

   task automatic idle(input int n);
      ts_in = 8'h00; ts_in_valid = 1'b0; tag_in = -1; stat_clr = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      ts_in_valid = 1'b0; tag_in = -1; stat_clr = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_row(input int i);
      row_t r;
      int v0, s0, l0, e0, b0;
      logic [7:0] b;
      r = tbl[i];
      if (r.rst) do_reset();
      sel = r.sel;
      cur_len = r.sel ? 204 : 188;
      v0 = n_vld; s0 = n_sync; l0 = n_last; e0 = n_err; b0 = n_bad;
      for (int j = 0; j < cur_len; j++) begin
         b = (j == 0) ? r.sync : ((j == r.sidx) ? r.sval : pay(j));
         drive_byte(b, j, r.gaps, r.clr && (j == 1));
      end
      idle(3);
      check($sformatf("r%0d_vld_cnt", i),  n_vld - v0,  r.out ? cur_len : 0);
      check($sformatf("r%0d_sync_cnt", i), n_sync - s0, {31'd0, r.out});
      check($sformatf("r%0d_last_cnt", i), n_last - l0, {31'd0, r.out});
      check($sformatf("r%0d_err_cnt", i),  n_err - e0,  {31'd0, r.err});
      check($sformatf("r%0d_stream", i),   n_bad - b0,  0);
      check($sformatf("r%0d_lock", i),     {31'd0, m_lock}, {31'd0, r.lock});
      check($sformatf("r%0d_sync_err", i), {16'd0, m_serr}, STAT_EN ? r.serr : 0);
      check($sformatf("r%0d_lock_loss", i), {16'd0, m_loss}, STAT_EN ? r.loss : 0);
   endtask

   // Locked mid-packet, then asynchronous reset between clock edges
   task automatic mid_reset_seq();
      sel = 1'b0; cur_len = 188;
      for (int j = 0; j < 90; j++) drive_byte((j == 0) ? 8'h47 : pay(j), j, 1'b0, 1'b0);
      check("mid_vld_before_rst",  {31'd0, m_vld},  1);
      check("mid_lock_before_rst", {31'd0, m_lock}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out",   {24'd0, m_out},  0);
      check("rst_vld",   {31'd0, m_vld},  0);
      check("rst_sync",  {31'd0, m_sync}, 0);
      check("rst_last",  {31'd0, m_last}, 0);
      check("rst_err",   {31'd0, m_err},  0);
      check("rst_lock",  {31'd0, m_lock}, 0);
      check("rst_serr",  {16'd0, m_serr}, 0);
      check("rst_loss",  {16'd0, m_loss}, 0);
      ts_in_valid = 1'b0; tag_in = -1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      n_vld = 0; n_sync = 0; n_last = 0; n_err = 0; n_bad = 0;
      sel = 1'b0; cur_len = 188;
      rst_n = 1'b0; ts_in = 8'h00; ts_in_valid = 1'b0; stat_clr = 1'b0; tag_in = -1;
      #3;
      check("init_vld",  {31'd0, a_vld},  0);
      check("init_lock", {31'd0, a_lock}, 0);
      check("init_out",  {24'd0, a_out},  0);

      //          rst s  g  c  sync   sidx sval   out err lock serr loss
      // Clean lock at 188: lock on 4th sync
      tbl.push_back(mk(1, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r0  candidate
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r1
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r2
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r3  lock
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r4
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r5
      // Flywheel: two misses held, then a good sync
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 1, 1, 1, 1, 0));   // r6
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 1, 1, 1, 2, 0));   // r7
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 2, 0));   // r8
      // Loss of lock on the third miss, then relock after 4 good syncs
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 1, 1, 1, 3, 0));   // r9
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 1, 1, 1, 4, 0));   // r10
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 0, 0, 0, 5, 1));   // r11 unlock
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 5, 1));   // r12
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 5, 1));   // r13
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 5, 1));   // r14
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 5, 1));   // r15 relock
      // stat_clr on the same edge as a miss: clear wins
      tbl.push_back(mk(0, 0, 0, 1, 8'h00, -1, 8'h00, 1, 1, 1, 0, 0));   // r16
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r17
      tbl.push_back(mk(0, 0, 0, 0, 8'h00, -1, 8'h00, 1, 1, 1, 1, 0));   // r18
      // After mid-packet reset: false sync in payload, its +188 byte is 0x00
      tbl.push_back(mk(0, 0, 0, 0, 8'h01, 100, 8'h47, 0, 0, 0, 0, 0));  // r19
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, 100, 8'h00, 0, 0, 0, 0, 0));  // r20 verify fails
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r21 candidate
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r22
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r23
      tbl.push_back(mk(0, 0, 0, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r24 lock
      // 204-byte mode with random valid gaps
      tbl.push_back(mk(1, 1, 1, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r25
      tbl.push_back(mk(0, 1, 1, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r26
      tbl.push_back(mk(0, 1, 1, 0, 8'h47, -1, 8'h00, 0, 0, 0, 0, 0));   // r27
      tbl.push_back(mk(0, 1, 1, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r28 lock
      tbl.push_back(mk(0, 1, 1, 0, 8'h47, -1, 8'h00, 1, 0, 1, 0, 0));   // r29
      tbl.push_back(mk(0, 1, 1, 0, 8'h00, -1, 8'h00, 1, 1, 1, 1, 0));   // r30 flywheel

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == 19) mid_reset_seq();
         run_row(i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
